// File: rtl/uartlog_decode_if.sv
// Bus bundle between a uartlog DAQ source, the decoder and the host readout port.
// The master side is the producer/host; the slave side is the decoder.
interface uartlog_decode_if;
  logic        daq_req;
  logic        daq_grant;
  logic [31:0] daq_data;
  logic        daq_valid;
  logic        daq_end;
  logic        out_dir;
  logic [7:0]  out_byte;
  logic [47:0] out_time;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] err_count;
  logic [15:0] drop_count;

  modport master (
    output daq_req, daq_data, daq_valid, daq_end, out_ready,
    input  daq_grant, out_dir, out_byte, out_time, out_valid, err_count, drop_count
  );

  modport slave (
    input  daq_req, daq_data, daq_valid, daq_end, out_ready,
    output daq_grant, out_dir, out_byte, out_time, out_valid, err_count, drop_count
  );
endinterface

// File: rtl/uartlog_decode.sv
// Grants a DAQ source, parses MCU_RX/TX short and long records, rebuilds 48-bit
// timestamps and queues {dir, byte, time} in a first-word-fall-through FIFO.
module uartlog_decode #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            rst,
  uartlog_decode_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] HIGH  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          grant_q, grant_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dir_q, dir_d;
  logic [7:0]    byte_q, byte_d;
  logic [15:0]   lo_q, lo_d;
  logic [31:0]   th_q, th_d;
  logic          thv_q, thv_d;
  logic [15:0]   err_q, drop_q;

  logic          push_req, err_inc;
  logic [56:0]   push_data;
  logic [7:0]    wtype;
  logic          is_short, is_long;

  logic [56:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q, fill;
  logic          full, empty, pop, push_en, drop;
  logic [56:0]   head;

  assign wtype    = bus.daq_data[31:24];
  assign is_short = (wtype == 8'd8) || (wtype == 8'd10);
  assign is_long  = (wtype == 8'd9) || (wtype == 8'd11);

  always_comb begin
    state_d   = state_q;
    grant_d   = 1'b0;
    timer_d   = timer_q;
    dir_d     = dir_q;
    byte_d    = byte_q;
    lo_d      = lo_q;
    th_d      = th_q;
    thv_d     = thv_q;
    push_req  = 1'b0;
    push_data = '0;
    err_inc   = 1'b0;
    if (state_q == IDLE) begin
      if (bus.daq_req) begin
        grant_d = 1'b1;
        state_d = RECV;
        timer_d = '0;
      end
    end else if (bus.daq_valid) begin
      timer_d = '0;
      case (state_q)
        RECV: begin
          // Type bit 1 separates TX (10/11) from RX (8/9).
          if (is_short && bus.daq_end) begin
            if (thv_q) begin
              push_req  = 1'b1;
              push_data = {wtype[1], bus.daq_data[23:16], th_q, bus.daq_data[15:0]};
            end else begin
              err_inc = 1'b1;
            end
            state_d = IDLE;
          end else if (is_long && !bus.daq_end) begin
            dir_d   = wtype[1];
            byte_d  = bus.daq_data[23:16];
            lo_d    = bus.daq_data[15:0];
            state_d = HIGH;
          end else begin
            err_inc = 1'b1;
            state_d = bus.daq_end ? IDLE : DRAIN;
          end
        end
        HIGH: begin
          th_d      = bus.daq_data;
          thv_d     = 1'b1;
          push_req  = 1'b1;
          push_data = {dir_q, byte_q, bus.daq_data, lo_q};
          if (bus.daq_end) begin
            state_d = IDLE;
          end else begin
            err_inc = 1'b1;
            state_d = DRAIN;
          end
        end
        default: begin
          if (bus.daq_end) state_d = IDLE;
        end
      endcase
    end else if (timer_q == TMAX) begin
      err_inc = 1'b1;
      state_d = IDLE;
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  assign fill    = wr_ptr_q - rd_ptr_q;
  assign empty   = (fill == '0);
  assign full    = (fill == (AW+1)'(FIFO_DEPTH));
  assign pop     = !empty && bus.out_ready;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push_en = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      timer_q  <= '0;
      dir_q    <= 1'b0;
      byte_q   <= '0;
      lo_q     <= '0;
      th_q     <= '0;
      thv_q    <= 1'b0;
      err_q    <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      byte_q  <= byte_d;
      lo_q    <= lo_d;
      th_q    <= th_d;
      thv_q   <= thv_d;
      if (err_inc && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign head           = mem[rd_ptr_q[AW-1:0]];
  assign bus.daq_grant  = grant_q;
  assign bus.out_valid  = !empty;
  assign bus.out_dir    = head[56];
  assign bus.out_byte   = head[55:48];
  assign bus.out_time   = head[47:0];
  assign bus.err_count  = err_q;
  assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_uartlog_decode.sv
// Directed bench for uartlog_decode: long/short decode, reset, error drain,
// FIFO overflow with simultaneous push/pop, and timeouts.
module tb_uartlog_decode;
  logic clk = 1'b0;
  logic rst;
  int   compared = 0;
  int   mismatched = 0;
  logic got;

  uartlog_decode_if bus ();

  uartlog_decode #(.FIFO_DEPTH(8), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic request(output logic granted);
    granted = 1'b0;
    bus.daq_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.daq_grant) begin
        granted = 1'b1;
        break;
      end
    end
    bus.daq_req = 1'b0;
  endtask

  task automatic send(input logic [31:0] data, input logic last);
    bus.daq_data  = data;
    bus.daq_end   = last;
    bus.daq_valid = 1'b1;
    tick();
    bus.daq_valid = 1'b0;
    bus.daq_end   = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.daq_req   = 1'b0;
    bus.daq_data  = '0;
    bus.daq_valid = 1'b0;
    bus.daq_end   = 1'b0;
    bus.out_ready = 1'b0;
    do_reset();

    check("rst_grant", 64'(bus.daq_grant), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_err", 64'(bus.err_count), 64'd0);
    check("rst_drop", 64'(bus.drop_count), 64'd0);

    // Long RX record
    request(got);
    check("t1_grant", 64'(got), 64'd1);
    tick();
    check("t1_grant_pulse", 64'(bus.daq_grant), 64'd0);
    send(32'h0941_1234, 1'b0);
    send(32'h0000_0005, 1'b1);
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_dir", 64'(bus.out_dir), 64'd0);
    check("t1_byte", 64'(bus.out_byte), 64'h41);
    check("t1_time", 64'(bus.out_time), 64'h0000_0005_1234);
    check("t1_err", 64'(bus.err_count), 64'd0);
    pop_one();
    check("t1_popped", 64'(bus.out_valid), 64'd0);

    // Short TX reusing the latched high time
    request(got);
    check("t2_grant", 64'(got), 64'd1);
    send(32'h0A42_2000, 1'b1);
    check("t2_dir", 64'(bus.out_dir), 64'd1);
    check("t2_byte", 64'(bus.out_byte), 64'h42);
    check("t2_time", 64'(bus.out_time), 64'h0000_0005_2000);
    pop_one();

    // Short record with no valid high time after reset
    do_reset();
    request(got);
    send(32'h0855_0001, 1'b1);
    tick();
    check("t3_nopush", 64'(bus.out_valid), 64'd0);
    check("t3_err", 64'(bus.err_count), 64'd1);

    // Unknown type, drained junk
    do_reset();
    request(got);
    send(32'h0700_0000, 1'b0);
    send(32'hDEAD_BEEF, 1'b0);
    send(32'h0941_0000, 1'b1);
    tick();
    check("t4_err", 64'(bus.err_count), 64'd1);
    check("t4_nopush", 64'(bus.out_valid), 64'd0);
    request(got);
    check("t4_regrant", 64'(got), 64'd1);
    send(32'h0900_0000, 1'b0);
    send(32'h0000_0001, 1'b1);
    pop_one();

    // Fill FIFO past capacity with short RX records
    for (int i = 0; i < 10; i++) begin
      request(got);
      send({8'h08, 8'(i), 16'(i * 16)}, 1'b1);
    end
    check("t5_valid", 64'(bus.out_valid), 64'd1);
    check("t5_drop", 64'(bus.drop_count), 64'd2);
    check("t5_err", 64'(bus.err_count), 64'd1);
    check("t5_head_time", 64'(bus.out_time), 64'h0000_0001_0000);
    // Push and pop together while full
    request(got);
    bus.out_ready = 1'b1;
    send(32'h08AA_0ABC, 1'b1);
    bus.out_ready = 1'b0;
    check("t5_fullpp_drop", 64'(bus.drop_count), 64'd2);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("t5_byte%0d", i), 64'(bus.out_byte), 64'(i));
      pop_one();
    end
    check("t5_last_byte", 64'(bus.out_byte), 64'hAA);
    check("t5_last_time", 64'(bus.out_time), 64'h0000_0001_0ABC);
    pop_one();
    check("t5_empty", 64'(bus.out_valid), 64'd0);

    // Timeout waiting for the first word
    do_reset();
    request(got);
    repeat (254) tick();
    check("t6_before_to", 64'(bus.err_count), 64'd0);
    tick();
    check("t6_timeout", 64'(bus.err_count), 64'd1);
    request(got);
    check("t6_regrant", 64'(got), 64'd1);
    send(32'h0B33_4444, 1'b0);
    repeat (256) tick();
    check("t6_hdr_stall_err", 64'(bus.err_count), 64'd2);
    check("t6_hdr_nopush", 64'(bus.out_valid), 64'd0);
    request(got);
    check("t6_final_grant", 64'(got), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
